// File: rtl/axi_id_pkg.sv
// Shared ID-tracking constants and counter-width helper, also used by axi_id_convertor.
// Pure declarations: no latency, no flow control.
package axi_id_pkg;

    localparam int ID_WIDTH   = 8;
    localparam int MAX_PER_ID = 4;
    localparam int TOTAL_CAP  = 16;

    // A counter that must reach max_v inclusive needs clog2(max_v+1) bits.
    function automatic int cnt_width(input int max_v);
        return $clog2(max_v + 1);
    endfunction

    localparam int CNT_W   = cnt_width(MAX_PER_ID);
    localparam int TOT_W   = cnt_width(TOTAL_CAP);
    localparam int NUM_IDS = 1 << ID_WIDTH;

endpackage

// File: rtl/axi_id_cnt_bank.sv
// Per-ID and total outstanding counters for one direction; address gating is combinational
// (zero latency), blocks when the ID or the total is full; responses on an empty ID set a sticky error.
module axi_id_cnt_bank
    import axi_id_pkg::*;
#(
    parameter int IDW     = 8,
    parameter int MAX_CNT = 4,
    parameter int CAP     = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_req_vld,
    input  logic           i_req_rdy,
    input  logic [IDW-1:0] i_req_id,
    output logic           o_fwd_vld,
    output logic           o_acc_rdy,
    input  logic           i_rsp_vld,
    input  logic [IDW-1:0] i_rsp_id,
    output logic           o_idle,
    output logic           o_err
);

    localparam int CW  = cnt_width(MAX_CNT);
    localparam int TW  = cnt_width(CAP);
    localparam int NID = 1 << IDW;
    localparam logic [CW-1:0] MAX_V = CW'(MAX_CNT);
    localparam logic [TW-1:0] CAP_V = TW'(CAP);

    logic [CW-1:0] r_cnt [NID];
    logic [TW-1:0] r_tot;
    logic          r_err;

    logic w_blk;
    logic w_inc;
    logic w_rsp_empty;
    logic w_dec;
    logic w_bad;
    logic w_same;

    assign w_blk       = (r_cnt[i_req_id] == MAX_V) || (r_tot == CAP_V);
    assign o_fwd_vld   = i_req_vld & ~w_blk;
    assign o_acc_rdy   = i_req_rdy & ~w_blk;
    assign w_inc       = o_fwd_vld & i_req_rdy;
    assign w_rsp_empty = (r_cnt[i_rsp_id] == '0);
    assign w_dec       = i_rsp_vld & ~w_rsp_empty;
    assign w_bad       = i_rsp_vld & w_rsp_empty;
    assign w_same      = w_inc & w_dec & (i_req_id == i_rsp_id);

    // Increments only happen while unblocked, so no counter can pass its cap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NID; i++) begin
                r_cnt[i] <= '0;
            end
            r_tot <= '0;
            r_err <= 1'b0;
        end else begin
            if (!w_same) begin
                if (w_inc) r_cnt[i_req_id] <= r_cnt[i_req_id] + CW'(1);
                if (w_dec) r_cnt[i_rsp_id] <= r_cnt[i_rsp_id] - CW'(1);
            end
            if (w_inc && !w_dec)      r_tot <= r_tot + TW'(1);
            else if (w_dec && !w_inc) r_tot <= r_tot - TW'(1);
            r_err <= r_err | w_bad;
        end
    end

    assign o_idle = (r_tot == '0);
    assign o_err  = r_err;

endmodule

// File: rtl/axi_id_tracker.sv
// Limits outstanding AXI reads/writes per ID and in total; AR/AW gating is combinational (zero latency),
// a full ID or full total holds off valid/ready until a counted R-last or B frees a slot.
module axi_id_tracker #(
    parameter int ID_WIDTH   = axi_id_pkg::ID_WIDTH,
    parameter int MAX_PER_ID = axi_id_pkg::MAX_PER_ID,
    parameter int TOTAL_CAP  = axi_id_pkg::TOTAL_CAP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_arvalid,
    output logic                s_arready,
    input  logic [ID_WIDTH-1:0] s_arid,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [ID_WIDTH-1:0] s_awid,
    output logic                m_awvalid,
    input  logic                m_awready,
    input  logic                rvalid,
    input  logic                rready,
    input  logic                rlast,
    input  logic [ID_WIDTH-1:0] rid,
    input  logic                bvalid,
    input  logic                bready,
    input  logic [ID_WIDTH-1:0] bid,
    output logic                rd_idle,
    output logic                wr_idle,
    output logic                rd_err,
    output logic                wr_err
);

    logic w_r_done;
    logic w_b_done;

    // Only the last R beat retires a read; B has a single beat.
    assign w_r_done = rvalid & rready & rlast;
    assign w_b_done = bvalid & bready;

    axi_id_cnt_bank #(
        .IDW     (ID_WIDTH),
        .MAX_CNT (MAX_PER_ID),
        .CAP     (TOTAL_CAP)
    ) u_rd (
        .clk       (clk),
        .rst       (rst),
        .i_req_vld (s_arvalid),
        .i_req_rdy (m_arready),
        .i_req_id  (s_arid),
        .o_fwd_vld (m_arvalid),
        .o_acc_rdy (s_arready),
        .i_rsp_vld (w_r_done),
        .i_rsp_id  (rid),
        .o_idle    (rd_idle),
        .o_err     (rd_err)
    );

    axi_id_cnt_bank #(
        .IDW     (ID_WIDTH),
        .MAX_CNT (MAX_PER_ID),
        .CAP     (TOTAL_CAP)
    ) u_wr (
        .clk       (clk),
        .rst       (rst),
        .i_req_vld (s_awvalid),
        .i_req_rdy (m_awready),
        .i_req_id  (s_awid),
        .o_fwd_vld (m_awvalid),
        .o_acc_rdy (s_awready),
        .i_rsp_vld (w_b_done),
        .i_rsp_id  (bid),
        .o_idle    (wr_idle),
        .o_err     (wr_err)
    );

endmodule

// File: tb/tb_axi_id_tracker.sv
// Directed bench for axi_id_tracker with default parameters (ID_WIDTH 8, 4 per ID, 16 total).
module tb_axi_id_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_arvalid, s_arready, m_arvalid, m_arready;
    logic [7:0] s_arid;
    logic       s_awvalid, s_awready, m_awvalid, m_awready;
    logic [7:0] s_awid;
    logic       rvalid, rready, rlast;
    logic [7:0] rid;
    logic       bvalid, bready;
    logic [7:0] bid;
    logic       rd_idle, wr_idle, rd_err, wr_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_id_tracker dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rid(rid),
        .bvalid(bvalid), .bready(bready), .bid(bid),
        .rd_idle(rd_idle), .wr_idle(wr_idle), .rd_err(rd_err), .wr_err(wr_err)
    );

    // Stimulus helpers: each is entered and left at posedge+1.
    task automatic clr_inputs();
        s_arvalid = 0; s_arid = 0; m_arready = 1;
        s_awvalid = 0; s_awid = 0; m_awready = 1;
        rvalid = 0; rready = 0; rlast = 0; rid = 0;
        bvalid = 0; bready = 0; bid = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        clr_inputs();
        rst = 1; #2; rst = 0;
        step();
    endtask

    task automatic do_ar(input logic [7:0] id);
        s_arvalid = 1; s_arid = id; step(); s_arvalid = 0;
    endtask

    task automatic do_aw(input logic [7:0] id);
        s_awvalid = 1; s_awid = id; step(); s_awvalid = 0;
    endtask

    task automatic do_r(input logic [7:0] id, input logic last);
        rvalid = 1; rready = 1; rlast = last; rid = id; step();
        rvalid = 0; rready = 0; rlast = 0;
    endtask

    task automatic do_b(input logic [7:0] id);
        bvalid = 1; bready = 1; bid = id; step(); bvalid = 0; bready = 0;
    endtask

    task automatic test_reset();
        clr_inputs();
        rst = 1; s_arvalid = 1; s_awvalid = 1; #3;
        n_chk++; if (rd_idle !== 1'b1) begin n_fail++; $display("FAIL reset_rd_idle got %b want 1", rd_idle); end
        n_chk++; if (wr_idle !== 1'b1) begin n_fail++; $display("FAIL reset_wr_idle got %b want 1", wr_idle); end
        n_chk++; if ({rd_err, wr_err} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got %b want 00", {rd_err, wr_err}); end
        n_chk++; if ({m_arvalid, s_arready, m_awvalid, s_awready} !== 4'b1111) begin
            n_fail++; $display("FAIL reset_gating got %b want 1111", {m_arvalid, s_arready, m_awvalid, s_awready}); end
        step(); step();
        rst = 0; s_arvalid = 0; s_awvalid = 0;
        step();
    endtask

    task automatic test_per_id_limit();
        apply_reset();
        for (int i = 0; i < 4; i++) do_ar(8'd3);
        s_arvalid = 1; s_arid = 8'd3; #1;
        n_chk++; if ({s_arready, m_arvalid} !== 2'b00) begin n_fail++; $display("FAIL id_full_stall got %b want 00", {s_arready, m_arvalid}); end
        s_arid = 8'd5; #1;
        n_chk++; if ({s_arready, m_arvalid} !== 2'b11) begin n_fail++; $display("FAIL other_id_pass got %b want 11", {s_arready, m_arvalid}); end
        step();
        s_arid = 8'd3; rvalid = 1; rready = 1; rlast = 1; rid = 8'd3; #1;
        n_chk++; if (s_arready !== 1'b0) begin n_fail++; $display("FAIL stall_before_free got %b want 0", s_arready); end
        step();
        rvalid = 0; rready = 0; rlast = 0;
        n_chk++; if ({s_arready, m_arvalid} !== 2'b11) begin n_fail++; $display("FAIL unblock_after_free got %b want 11", {s_arready, m_arvalid}); end
        step();
        s_arvalid = 0;
        n_chk++; if (dut.u_rd.r_cnt[3] !== 3'd4) begin n_fail++; $display("FAIL id3_count got %0d want 4", dut.u_rd.r_cnt[3]); end
        n_chk++; if (dut.u_rd.r_tot !== 5'd5) begin n_fail++; $display("FAIL rd_tot_after_id_test got %0d want 5", dut.u_rd.r_tot); end
        for (int i = 0; i < 4; i++) do_r(8'd3, 1'b1);
        do_r(8'd5, 1'b1);
        n_chk++; if ({rd_idle, rd_err} !== 2'b10) begin n_fail++; $display("FAIL drain_idle got %b want 10", {rd_idle, rd_err}); end
    endtask

    task automatic test_total_cap();
        apply_reset();
        for (int i = 0; i < 16; i++) do_ar(8'(i % 8));
        do_aw(8'd4);
        n_chk++; if (dut.u_rd.r_tot !== 5'd16) begin n_fail++; $display("FAIL rd_tot_full got %0d want 16", dut.u_rd.r_tot); end
        s_arvalid = 1; s_arid = 8'd9; #1;
        n_chk++; if ({s_arready, m_arvalid} !== 2'b00) begin n_fail++; $display("FAIL total_block got %b want 00", {s_arready, m_arvalid}); end
        do_b(8'd4);
        n_chk++; if ({s_arready, m_arvalid} !== 2'b00) begin n_fail++; $display("FAIL b_no_unblock got %b want 00", {s_arready, m_arvalid}); end
        n_chk++; if ({wr_idle, wr_err, rd_idle} !== 3'b100) begin n_fail++; $display("FAIL wr_drain_indep got %b want 100", {wr_idle, wr_err, rd_idle}); end
        s_arvalid = 0;
    endtask

    task automatic test_burst();
        apply_reset();
        do_ar(8'd2);
        for (int i = 0; i < 3; i++) do_r(8'd2, 1'b0);
        n_chk++; if (dut.u_rd.r_cnt[2] !== 3'd1) begin n_fail++; $display("FAIL nonlast_no_dec got %0d want 1", dut.u_rd.r_cnt[2]); end
        rvalid = 1; rready = 1; rlast = 1; rid = 8'd2; #1;
        n_chk++; if (rd_idle !== 1'b0) begin n_fail++; $display("FAIL idle_before_last got %b want 0", rd_idle); end
        step();
        rvalid = 0; rready = 0; rlast = 0;
        n_chk++; if ({rd_idle, rd_err} !== 2'b10) begin n_fail++; $display("FAIL idle_after_last got %b want 10", {rd_idle, rd_err}); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        do_ar(8'd1); do_ar(8'd1); do_ar(8'd6);
        s_arvalid = 1; s_arid = 8'd1; rvalid = 1; rready = 1; rlast = 1; rid = 8'd1;
        step();
        n_chk++; if (dut.u_rd.r_cnt[1] !== 3'd2) begin n_fail++; $display("FAIL same_id_cnt got %0d want 2", dut.u_rd.r_cnt[1]); end
        n_chk++; if (dut.u_rd.r_tot !== 5'd3) begin n_fail++; $display("FAIL same_id_tot got %0d want 3", dut.u_rd.r_tot); end
        s_arid = 8'd6;
        step();
        s_arvalid = 0; rvalid = 0; rready = 0; rlast = 0;
        n_chk++; if ({dut.u_rd.r_cnt[1], dut.u_rd.r_cnt[6]} !== {3'd1, 3'd2}) begin
            n_fail++; $display("FAIL diff_id_cnts got %0d/%0d want 1/2", dut.u_rd.r_cnt[1], dut.u_rd.r_cnt[6]); end
        n_chk++; if (dut.u_rd.r_tot !== 5'd3) begin n_fail++; $display("FAIL diff_id_tot got %0d want 3", dut.u_rd.r_tot); end
    endtask

    task automatic test_b_underflow();
        apply_reset();
        do_aw(8'd2); do_ar(8'd1);
        do_b(8'd7);
        n_chk++; if ({wr_err, rd_err} !== 2'b10) begin n_fail++; $display("FAIL b_underflow_err got %b want 10", {wr_err, rd_err}); end
        n_chk++; if ({dut.u_wr.r_cnt[7], dut.u_wr.r_tot} !== {3'd0, 5'd1}) begin
            n_fail++; $display("FAIL b_underflow_cnt got %0d/%0d want 0/1", dut.u_wr.r_cnt[7], dut.u_wr.r_tot); end
        step(); step();
        do_b(8'd2);
        n_chk++; if ({wr_err, wr_idle, rd_idle} !== 3'b110) begin n_fail++; $display("FAIL wr_err_sticky got %b want 110", {wr_err, wr_idle, rd_idle}); end
    endtask

    task automatic test_write_path();
        apply_reset();
        s_awvalid = 1; s_awid = 8'd3;
        for (int i = 0; i < 4; i++) step();
        n_chk++; if ({s_awready, m_awvalid} !== 2'b00) begin n_fail++; $display("FAIL aw_b2b_block got %b want 00", {s_awready, m_awvalid}); end
        s_arvalid = 1; s_arid = 8'd3; #1;
        n_chk++; if ({s_arready, m_arvalid} !== 2'b11) begin n_fail++; $display("FAIL ar_indep_of_aw got %b want 11", {s_arready, m_arvalid}); end
        s_arvalid = 0; s_awvalid = 0;
        n_chk++; if (dut.u_wr.r_cnt[3] !== 3'd4) begin n_fail++; $display("FAIL aw_cnt got %0d want 4", dut.u_wr.r_cnt[3]); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 6; i++) do_ar(8'(i));
        n_chk++; if (rd_idle !== 1'b0) begin n_fail++; $display("FAIL six_outstanding got %b want 0", rd_idle); end
        rst = 1; #1;
        n_chk++; if (rd_idle !== 1'b1) begin n_fail++; $display("FAIL async_reset_idle got %b want 1", rd_idle); end
        #1; rst = 0;
        step();
        do_r(8'd0, 1'b1);
        n_chk++; if ({rd_err, rd_idle, wr_err} !== 3'b110) begin n_fail++; $display("FAIL post_reset_rsp got %b want 110", {rd_err, rd_idle, wr_err}); end
    endtask

    initial begin
        test_reset();
        test_per_id_limit();
        test_total_cap();
        test_burst();
        test_simultaneous();
        test_b_underflow();
        test_write_path();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_id_tracker.md
AXI_ID_TRACKER -- requirements
Module: axi_id_tracker

Interface
REQ-001 Parameters SHALL be:
- ID_WIDTH, default 8, virtual AXI ID width.
- MAX_PER_ID, default 4, outstanding transactions allowed per ID per direction.
- TOTAL_CAP, default 16, outstanding transactions allowed per direction across all IDs.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.

REQ-003 Read address ports SHALL be:
- s_arvalid, in, 1, from the master.
- s_arready, out, 1, to the master.
- s_arid, in, ID_WIDTH.
- m_arvalid, out, 1, to the slave.
- m_arready, in, 1, from the slave.

REQ-004 Write address ports SHALL be s_awvalid, s_awready, s_awid, m_awvalid, m_awready, with the same directions and widths as REQ-003.

REQ-005 Response ports SHALL be:
- rvalid, in, 1.
- rready, in, 1.
- rlast, in, 1.
- rid, in, ID_WIDTH.
- bvalid, in, 1.
- bready, in, 1.
- bid, in, ID_WIDTH.
All of these are observed only and never driven.

REQ-006 Status ports SHALL be:
- rd_idle, out, 1, high when no reads are outstanding.
- wr_idle, out, 1, high when no writes are outstanding.
- rd_err, out, 1, sticky error flag.
- wr_err, out, 1, sticky error flag.

Function
REQ-007 The block SHALL keep per-ID read counters rd_cnt[2^ID_WIDTH] and per-ID write counters wr_cnt[2^ID_WIDTH], each clog2(MAX_PER_ID+1) bits wide, plus totals rd_tot and wr_tot, each clog2(TOTAL_CAP+1) bits wide.

REQ-008 The read block condition SHALL be rd_blk = (rd_cnt[s_arid] == MAX_PER_ID) or (rd_tot == TOTAL_CAP).

REQ-009 Address gating SHALL be combinational:
- m_arvalid = s_arvalid and not rd_blk.
- s_arready = m_arready and not rd_blk.
- The AR path SHALL therefore add zero latency.

REQ-010 The write path SHALL mirror REQ-008 and REQ-009 using wr_cnt, wr_tot, s_awid, m_awvalid and s_awready.

REQ-011 On m_arvalid and m_arready both high, the block SHALL increment rd_cnt[s_arid] and rd_tot at the next clk edge.

REQ-012 On rvalid, rready and rlast all high, the block SHALL decrement rd_cnt[rid] and rd_tot at the next clk edge. Non-last R beats SHALL not change any counter.

REQ-013 On bvalid and bready both high, the block SHALL decrement wr_cnt[bid] and wr_tot at the next clk edge.

REQ-014 Simultaneous increment and decrement in the same cycle SHALL behave as follows:
- Same ID: that ID's counter and the total SHALL be unchanged.
- Different IDs: each ID counter SHALL update independently and the total SHALL be unchanged.

REQ-015 A counted R beat (rlast high) or B handshake arriving when the counter for its ID is 0 SHALL:
- set rd_err or wr_err to 1 at the next edge;
- leave all counters unchanged, so there is no underflow.

REQ-016 rd_err and wr_err SHALL stay set until rst.

REQ-017 rd_idle SHALL equal (rd_tot == 0) and wr_idle SHALL equal (wr_tot == 0), both decoded from registers with no combinational input path.

REQ-018 A blocked request SHALL remain stalled, with s_arvalid held by the master, until a response frees capacity. s_arready SHALL then rise in the cycle after the freeing edge.

REQ-019 Counters SHALL never exceed MAX_PER_ID or TOTAL_CAP, and SHALL never wrap.

REQ-020 The read and write directions SHALL be fully independent.

Reset
REQ-021 Asserting rst SHALL asynchronously clear all counters and both error flags.

REQ-022 During reset:
- rd_idle and wr_idle SHALL be 1.
- m_arvalid and m_awvalid SHALL follow their REQ-009 and REQ-010 equations with all counters at 0, i.e. unblocked.

REQ-023 Reset asserted mid-transaction SHALL discard all tracking. Responses arriving after reset for pre-reset requests SHALL set the error flags per REQ-015.

Structure
REQ-024 The shared package axi_id_pkg SHALL hold ID_WIDTH and the derived counter-width constants, shared with axi_id_convertor.

REQ-025 One sub-module, axi_id_cnt_bank, SHALL implement the per-ID counters, the total, the block flag and the error logic. It SHALL be instantiated twice, once for reads and once for writes.

Verification
REQ-026 Four AR handshakes on ID 3 (default parameters) -> the fifth AR on ID 3 is stalled (s_arready=0, m_arvalid=0) while an AR on ID 5 passes in the same cycle. One R beat with rlast on ID 3 -> the stalled AR is accepted on the following cycle.

REQ-027 Sixteen ARs spread over IDs 0..7 -> rd_tot=16 and the seventeenth AR on ID 9 is blocked. A B response in this state SHALL not unblock it.

REQ-028 A burst of 4 R beats on ID 2 with rlast only on beat 4 -> rd_cnt[2] decrements once and rd_idle rises one cycle after beat 4.

REQ-029 AR on ID 1 and R-last on ID 1 in the same cycle while rd_cnt[1]=2 -> rd_cnt[1] stays 2 and rd_tot is unchanged.

REQ-030 B handshake on ID 7 with wr_cnt[7]=0 -> wr_err=1 sticky, all counters unchanged, rd_err stays 0.

REQ-031 rst asserted with 6 reads outstanding -> rd_idle=1 immediately. A subsequent R-last on ID 0 -> rd_err=1.
